// File: rtl/csr_diff_shadow.sv
// Difftest shadow of the M-mode CSRs and privilege level, fed through a small event FIFO.
// Optional feature: define CSR_DIFF_BYPASS_EN to apply an event directly when the FIFO is empty.
module csr_diff_shadow #(
    parameter int          HARTID      = 0,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [63:0] MSTATUS_RST = 64'h0000000a00000000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic                           ev_kind,
    input  logic [11:0]                    ev_addr,
    input  logic [63:0]                    ev_data,
    input  logic                           hold,
    input  logic [63:0]                    mip_in,
    output logic [1:0]                     priv,
    output logic [75:0]                    mstatus,
    output logic [75:0]                    mepc,
    output logic [75:0]                    mtval,
    output logic [75:0]                    mscratch,
    output logic [75:0]                    mcause,
    output logic [75:0]                    mtvec,
    output logic [75:0]                    mie,
    output logic [75:0]                    mip,
    output logic [31:0]                    hartid,
    output logic [$clog2(FIFO_DEPTH):0]    level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic        kind;
        logic [11:0] addr;
        logic [63:0] data;
    } ev_t;

    ev_t          mem_q [FIFO_DEPTH];
    ev_t          mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [63:0]  mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [63:0]  mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d, mip_q, mip_d;
    logic [1:0]   priv_q, priv_d;

    logic full_s, empty_s, push_s, pop_s, bypass_s, enq_s, apply_s;
    ev_t  in_ev_s, apply_ev_s;

    // FIFO control, event selection and shadow next-state
    always_comb begin
        full_s   = (count_q == LW'(FIFO_DEPTH));
        empty_s  = (count_q == {LW{1'b0}});
        push_s   = ev_valid && !full_s;
        pop_s    = !hold && !empty_s;
`ifdef CSR_DIFF_BYPASS_EN
        bypass_s = push_s && empty_s && !hold;
`else
        bypass_s = 1'b0;
`endif
        enq_s    = push_s && !bypass_s;
        apply_s  = pop_s || bypass_s;
        in_ev_s  = '{kind: ev_kind, addr: ev_addr, data: ev_data};
        if (pop_s) begin
            apply_ev_s = mem_q[rd_ptr_q];
        end else begin
            apply_ev_s = in_ev_s;
        end

        mem_d = mem_q;
        if (enq_s) begin
            mem_d[wr_ptr_q] = in_ev_s;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        wr_ptr_d = enq_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({enq_s, pop_s})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        priv_d     = priv_q;
        mip_d      = hold ? mip_q : mip_in;
        // mip is tracked from mip_in, so writes to 0x344 are consumed with no effect
        if (apply_s && !apply_ev_s.kind) begin
            case (apply_ev_s.addr)
                12'h300: mstatus_d  = apply_ev_s.data;
                12'h304: mie_d      = apply_ev_s.data;
                12'h305: mtvec_d    = apply_ev_s.data;
                12'h340: mscratch_d = apply_ev_s.data;
                12'h341: mepc_d     = apply_ev_s.data;
                12'h342: mcause_d   = apply_ev_s.data;
                12'h343: mtval_d    = apply_ev_s.data;
                default: mstatus_d  = mstatus_q;
            endcase
        end else if (apply_s && (apply_ev_s.data[1:0] != 2'b10)) begin
            priv_d = apply_ev_s.data[1:0];
        end else begin
            priv_d = priv_q;
        end
    end

    // State registers: FIFO storage, pointers and shadow CSRs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {LW{1'b0}};
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= 64'h0;
            mtvec_q    <= 64'h0;
            mscratch_q <= 64'h0;
            mepc_q     <= 64'h0;
            mcause_q   <= 64'h0;
            mtval_q    <= 64'h0;
            mip_q      <= 64'h0;
            priv_q     <= 2'b11;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
            priv_q     <= priv_d;
        end
    end

    assign ev_ready = !full_s;
    assign level    = count_q;
    assign priv     = priv_q;
    assign hartid   = 32'(HARTID);
    assign mstatus  = {12'h300, mstatus_q};
    assign mie      = {12'h304, mie_q};
    assign mtvec    = {12'h305, mtvec_q};
    assign mscratch = {12'h340, mscratch_q};
    assign mepc     = {12'h341, mepc_q};
    assign mcause   = {12'h342, mcause_q};
    assign mtval    = {12'h343, mtval_q};
    assign mip      = {12'h344, mip_q};
endmodule

// File: tb/tb_csr_diff_shadow.sv
// Directed table-driven bench for csr_diff_shadow (default build, FIFO_DEPTH 4).
module tb_csr_diff_shadow;
    logic        clock = 1'b0;
    logic        reset, ev_valid, ev_ready, ev_kind, hold;
    logic [11:0] ev_addr;
    logic [63:0] ev_data, mip_in;
    logic [1:0]  priv;
    logic [75:0] mstatus, mepc, mtval, mscratch, mcause, mtvec, mie, mip;
    logic [31:0] hartid;
    logic [2:0]  level;

    int n_vec = 0;
    int n_err = 0;

    csr_diff_shadow dut (
        .clock(clock), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_kind(ev_kind), .ev_addr(ev_addr), .ev_data(ev_data), .hold(hold),
        .mip_in(mip_in), .priv(priv), .mstatus(mstatus), .mepc(mepc), .mtval(mtval),
        .mscratch(mscratch), .mcause(mcause), .mtvec(mtvec), .mie(mie), .mip(mip),
        .hartid(hartid), .level(level)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        valid;
        logic        kind;
        logic [11:0] addr;
        logic [63:0] data;
        logic [63:0] mip;
        logic [3:0]  sel;
        logic [63:0] exp_val;
        logic [1:0]  exp_priv;
        logic [2:0]  exp_lvl;
    } vec_t;

    localparam logic [11:0] IDS [8] = '{12'h300, 12'h304, 12'h305, 12'h340,
                                        12'h341, 12'h342, 12'h343, 12'h344};
    localparam logic [3:0] S_MSTATUS = 4'd0, S_MIE = 4'd1, S_MTVEC = 4'd2, S_MSCRATCH = 4'd3,
                           S_MEPC = 4'd4, S_MCAUSE = 4'd5, S_MTVAL = 4'd6, S_MIP = 4'd7;

    vec_t tbl [16];

    function automatic logic [75:0] pick(input logic [3:0] s);
        case (s)
            4'd0:    pick = mstatus;
            4'd1:    pick = mie;
            4'd2:    pick = mtvec;
            4'd3:    pick = mscratch;
            4'd4:    pick = mepc;
            4'd5:    pick = mcause;
            4'd6:    pick = mtval;
            4'd7:    pick = mip;
            default: pick = 76'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic k, input logic [11:0] a, input logic [63:0] d);
        ev_valid = v;
        ev_kind  = k;
        ev_addr  = a;
        ev_data  = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 12'h341, 64'h80000004, 64'h11, S_MEPC, 64'h0, 2'd3, 3'd1};
        tbl[1]  = '{1'b0, 1'b0, 12'h000, 64'h0, 64'h22, S_MEPC, 64'h80000004, 2'd3, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 12'h000, 64'h0, 64'h33, S_MIP, 64'h33, 2'd3, 3'd0};
        tbl[3]  = '{1'b1, 1'b1, 12'h000, 64'h2, 64'h33, S_MIP, 64'h33, 2'd3, 3'd1};
        tbl[4]  = '{1'b1, 1'b0, 12'h7c0, 64'hff, 64'h44, S_MIP, 64'h44, 2'd3, 3'd1};
        tbl[5]  = '{1'b1, 1'b0, 12'h344, 64'h55, 64'h44, S_MIP, 64'h44, 2'd3, 3'd1};
        tbl[6]  = '{1'b0, 1'b0, 12'h000, 64'h0, 64'h44, S_MIP, 64'h44, 2'd3, 3'd0};
        tbl[7]  = '{1'b1, 1'b1, 12'h000, 64'h1, 64'h44, S_MSTATUS, 64'ha00000000, 2'd3, 3'd1};
        tbl[8]  = '{1'b1, 1'b0, 12'h300, 64'h1888, 64'h44, S_MSTATUS, 64'ha00000000, 2'd1, 3'd1};
        tbl[9]  = '{1'b1, 1'b0, 12'h304, 64'haaa, 64'h44, S_MSTATUS, 64'h1888, 2'd1, 3'd1};
        tbl[10] = '{1'b1, 1'b0, 12'h305, 64'h80000100, 64'h44, S_MIE, 64'haaa, 2'd1, 3'd1};
        tbl[11] = '{1'b1, 1'b0, 12'h342, 64'h8000000000000007, 64'h44, S_MTVEC, 64'h80000100, 2'd1, 3'd1};
        tbl[12] = '{1'b1, 1'b0, 12'h343, 64'hdeadbeefcafef00d, 64'h44, S_MCAUSE, 64'h8000000000000007, 2'd1, 3'd1};
        tbl[13] = '{1'b1, 1'b0, 12'h340, 64'h5, 64'h44, S_MTVAL, 64'hdeadbeefcafef00d, 2'd1, 3'd1};
        tbl[14] = '{1'b1, 1'b1, 12'h000, 64'h3, 64'h44, S_MSCRATCH, 64'h5, 2'd1, 3'd1};
        tbl[15] = '{1'b0, 1'b0, 12'h000, 64'h0, 64'h44, S_MSCRATCH, 64'h5, 2'd3, 3'd0};

        reset  = 1'b1;
        hold   = 1'b0;
        mip_in = 64'h0;
        drive(1'b0, 1'b0, 12'h0, 64'h0);
        #2;
        chk("rst_mstatus", mstatus, {12'h300, 64'ha00000000});
        chk("rst_priv", 76'(priv), 76'd3);
        chk("rst_level", 76'(level), 76'd0);
        chk("rst_ready", 76'(ev_ready), 76'd1);
        chk("rst_mepc", mepc, {12'h341, 64'h0});
        chk("hartid", 76'(hartid), 76'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].valid, tbl[i].kind, tbl[i].addr, tbl[i].data);
            mip_in = tbl[i].mip;
            tick();
            chk($sformatf("vec%0d_val", i), pick(tbl[i].sel), {IDS[tbl[i].sel], tbl[i].exp_val});
            chk($sformatf("vec%0d_priv", i), 76'(priv), 76'(tbl[i].exp_priv));
            chk($sformatf("vec%0d_level", i), 76'(level), 76'(tbl[i].exp_lvl));
        end

        // hold: fill the FIFO, state frozen, then drain in order
        hold   = 1'b1;
        mip_in = 64'h99;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 12'h340, 64'(k + 1));
            tick();
        end
        drive(1'b1, 1'b1, 12'h0, 64'h0);
        tick();
        chk("hold_level_full", 76'(level), 76'd4);
        chk("hold_ready_low", 76'(ev_ready), 76'd0);
        chk("hold_mscratch", mscratch, {12'h340, 64'h5});
        chk("hold_priv", 76'(priv), 76'd3);
        chk("hold_mip", mip, {12'h344, 64'h44});
        drive(1'b1, 1'b0, 12'h340, 64'h9);
        tick();
        chk("hold_full_level", 76'(level), 76'd4);
        hold = 1'b0;
        #1;
        chk("full_pop_ready", 76'(ev_ready), 76'd0);
        tick();
        chk("full_pop_level", 76'(level), 76'd3);
        chk("drain1_mscratch", mscratch, {12'h340, 64'h1});
        chk("drain_mip", mip, {12'h344, 64'h99});
        drive(1'b0, 1'b0, 12'h0, 64'h0);
        tick();
        chk("drain2_mscratch", mscratch, {12'h340, 64'h2});
        chk("drain2_level", 76'(level), 76'd2);
        tick();
        chk("drain3_mscratch", mscratch, {12'h340, 64'h3});
        chk("drain3_level", 76'(level), 76'd1);
        tick();
        chk("drain4_priv", 76'(priv), 76'd0);
        chk("drain4_level", 76'(level), 76'd0);
        tick();
        chk("drain_final_mscratch", mscratch, {12'h340, 64'h3});
        chk("drain_final_ready", 76'(ev_ready), 76'd1);

        // reset with three pending events flushes them
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 12'h341, 64'(k + 1));
            tick();
        end
        drive(1'b0, 1'b0, 12'h0, 64'h0);
        chk("pre_rst_level", 76'(level), 76'd3);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_mstatus", mstatus, {12'h300, 64'ha00000000});
        chk("mid_rst_priv", 76'(priv), 76'd3);
        chk("mid_rst_level", 76'(level), 76'd0);
        chk("mid_rst_ready", 76'(ev_ready), 76'd1);
        chk("mid_rst_mscratch", mscratch, {12'h340, 64'h0});
        @(negedge clock);
        reset = 1'b0;
        hold  = 1'b0;
        repeat (3) tick();
        chk("post_rst_mepc", mepc, {12'h341, 64'h0});
        chk("post_rst_level", 76'(level), 76'd0);
        chk("post_rst_priv", 76'(priv), 76'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
